synapse_crossbar: RTL and testbench

Parametrised axon-to-neuron connectivity store for the neuron core, successor to the single-word-per-axon synapse matrix. Connection bits are written and read back by the management SoC over a Wishbone slave port. A row-streaming engine delivers an axon's full connection row, NUM_NEURONS bits as 32-bit words, to the neuron array over a valid/ready handshake. Both agents share one single-port memory; Wishbone has priority.

---
 rtl/synapse_crossbar.sv | 148 ++++++++++++++
 tb/tb_synapse_crossbar.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_crossbar.sv
`default_nettype none
// ============================================================================
// Module   : synapse_crossbar
// Purpose  : Axon-to-neuron connectivity store. The management SoC reads and
//            writes it over a Wishbone slave port. A row-streaming engine
//            delivers one axon's connection row as 32-bit words over a
//            valid/ready handshake. Both agents share one single-port memory,
//            and Wishbone wins any conflict.
// Revision : 1.0 - initial release
// ============================================================================
module synapse_crossbar #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_AXONS   = 256,
  parameter int          NUM_NEURONS = 64
) (
  input  logic                                       wb_clk_i,
  input  logic                                       wb_rst_i,
  input  logic                                       wbs_cyc_i,
  input  logic                                       wbs_stb_i,
  input  logic                                       wbs_we_i,
  input  logic [3:0]                                 wbs_sel_i,
  input  logic [31:0]                                wbs_adr_i,
  input  logic [31:0]                                wbs_dat_i,
  output logic                                       wbs_ack_o,
  output logic [31:0]                                wbs_dat_o,
  input  logic                                       axon_valid_i,
  input  logic [((NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1)-1:0] axon_idx_i,
  output logic                                       axon_ready_o,
  output logic                                       row_valid_o,
  input  logic                                       row_ready_i,
  output logic [31:0]                                row_data_o,
  output logic [((NUM_NEURONS/32 > 1) ? $clog2(NUM_NEURONS/32) : 1)-1:0] row_word_o,
  output logic                                       row_last_o,
  output logic                                       busy_o
);

  localparam int WPR   = NUM_NEURONS / 32;
  localparam int DEPTH = NUM_AXONS * WPR;
  localparam int IW    = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
  localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter must be able to hold WPR itself (the "row fully loaded" value).
  localparam int CW    = $clog2(WPR + 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [IW-1:0]   r_axon;
  logic [CW-1:0]   r_cnt;

  // Wishbone decode. Addresses below the base wrap to huge offsets, so the
  // explicit lower-bound test is what rejects them.
  logic            w_wb_take;
  logic [31:0]     w_wb_word;
  logic            w_wb_in_range;
  logic [AW-1:0]   w_wb_idx;

  assign w_wb_take     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wb_rst_i;
  assign w_wb_word     = (wbs_adr_i - BASE_ADDR) >> 2;
  assign w_wb_in_range = (wbs_adr_i >= BASE_ADDR) && (w_wb_word < 32'(DEPTH));
  assign w_wb_idx      = w_wb_word[AW-1:0];

  // Stream read: only when Wishbone leaves the port free, the row is not yet
  // fully loaded and the output register can take a new word.
  logic            w_stream_rd;
  logic            w_row_in_range;
  logic [AW-1:0]   w_row_addr;

  assign w_stream_rd    = (r_state == S_STREAM) && !w_wb_take &&
                          (r_cnt < CW'(WPR)) && (!row_valid_o || row_ready_i);
  assign w_row_in_range = (32'(r_axon) < 32'(NUM_AXONS));
  assign w_row_addr     = AW'(r_axon) * AW'(WPR) + AW'(r_cnt);

  assign axon_ready_o = (r_state == S_IDLE);
  assign busy_o       = (r_state == S_STREAM);

  // Memory array: byte-lane writes from Wishbone; contents are never reset.
  always_ff @(posedge wb_clk_i) begin
    if (w_wb_take && wbs_we_i && w_wb_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) mem[w_wb_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

  // Wishbone response: one-cycle ack, read data held until the next read ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= w_wb_take;
      if (w_wb_take && !wbs_we_i)
        wbs_dat_o <= w_wb_in_range ? mem[w_wb_idx] : 32'h0;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: leave STREAM once the last word is handed over.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (axon_valid_i) w_state_nxt = S_STREAM;
      S_STREAM: if (row_valid_o && row_ready_i && row_last_o) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, word counter and the output register of the row stream.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_axon      <= '0;
      r_cnt       <= '0;
      row_valid_o <= 1'b0;
      row_data_o  <= 32'h0;
      row_word_o  <= '0;
      row_last_o  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && axon_valid_i) begin
        r_axon <= axon_idx_i;
        r_cnt  <= '0;
      end else if (w_stream_rd) begin
        r_cnt  <= r_cnt + 1'b1;
      end

      if (w_stream_rd) begin
        row_valid_o <= 1'b1;
        row_data_o  <= w_row_in_range ? mem[w_row_addr] : 32'h0;
        row_word_o  <= WW'(r_cnt);
        row_last_o  <= (r_cnt == CW'(WPR - 1));
      end else if (row_valid_o && row_ready_i) begin
        row_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_synapse_crossbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_synapse_crossbar
// Purpose  : Self-checking bench for synapse_crossbar. NUM_AXONS is 300 so
//            the 9-bit axon index can name rows beyond the array (e.g. 300).
// Revision : 1.0 - initial release
// ============================================================================
module tb_synapse_crossbar;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          NA    = 300;
  localparam int          NN    = 64;
  localparam int          WPR   = NN / 32;
  localparam int          DEPTH = NA * WPR;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        axon_valid;
  logic [8:0]  axon_idx;
  logic        axon_ready;
  logic        row_valid;
  logic        row_ready;
  logic [31:0] row_data;
  logic [0:0]  row_word;
  logic        row_last;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  synapse_crossbar #(
    .BASE_ADDR  (BASE),
    .NUM_AXONS  (NA),
    .NUM_NEURONS(NN)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .axon_valid_i(axon_valid),
    .axon_idx_i  (axon_idx),
    .axon_ready_o(axon_ready),
    .row_valid_o (row_valid),
    .row_ready_i (row_ready),
    .row_data_o  (row_data),
    .row_word_o  (row_word),
    .row_last_o  (row_last),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_win(a) ? model[(a - BASE) / 4] : 32'h0;
  endfunction

  function automatic logic [31:0] row_word_exp(input int axon, input int w);
    return (axon < NA) ? model[axon * WPR + w] : 32'h0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},    32'(ack),        32'h0);
    check({tag, "_dat"},    rdat,            32'h0);
    check({tag, "_aready"}, 32'(axon_ready), 32'h1);
    check({tag, "_rvalid"}, 32'(row_valid),  32'h0);
    check({tag, "_rdata"},  row_data,        32'h0);
    check({tag, "_rword"},  32'(row_word),   32'h0);
    check({tag, "_rlast"},  32'(row_last),   32'h0);
    check({tag, "_busy"},   32'(busy),       32'h0);
  endtask

  // Write: ack one cycle later for exactly one cycle; read data untouched.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    step();
    check("wr_ack", 32'(ack), 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
    check("wr_ack_drop", 32'(ack), 32'h0);
    check("wr_dat_hold", rdat, last_rd);
    if (in_win(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[(a - BASE) / 4][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic wb_read_check(input logic [31:0] a);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    step();
    check("rd_ack", 32'(ack), 32'h1);
    check("rd_data", rdat, model_read(a));
    last_rd = model_read(a);
    cyc = 1'b0; stb = 1'b0;
    step();
    check("rd_ack_drop", 32'(ack), 32'h0);
  endtask

  // Present a row request while idle; it is accepted at the next edge.
  task automatic request(input int axon);
    check("req_ready", 32'(axon_ready), 32'h1);
    axon_valid = 1'b1;
    axon_idx   = 9'(axon);
    step();
    axon_valid = 1'b0;
    check("req_taken_ready", 32'(axon_ready), 32'h0);
    check("req_taken_busy",  32'(busy),       32'h1);
  endtask

  // Drain the rest of a row, comparing every valid word against the expected
  // sequence (a held word must keep matching the same expected word).
  task automatic collect(input logic [31:0] e0, input logic [31:0] e1, input bit rnd);
    logic [31:0] exp_w [WPR];
    int n = 0;
    int cycles = 0;
    exp_w[0] = e0;
    exp_w[1] = e1;
    while (n < WPR && cycles < 200) begin
      row_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (row_valid) begin
        check("row_data", row_data,       exp_w[n]);
        check("row_word", 32'(row_word),  32'(n));
        check("row_last", 32'(row_last),  32'(n == WPR - 1));
        if (row_ready) n++;
      end
      step();
      cycles++;
    end
    if (n < WPR) check("row_timeout", 32'(n), 32'(WPR));
    row_ready = 1'b1;
    check("row_end_valid", 32'(row_valid),  32'h0);
    check("row_end_ready", 32'(axon_ready), 32'h1);
  endtask

  initial begin
    logic [31:0] old0, new0, new1;
    int          ax;
    logic [31:0] ra;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0; axon_valid = 1'b0; axon_idx = 9'h0;
    row_ready = 1'b1; last_rd = 32'h0;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Fill every word so no read ever returns X.
    for (int i = 0; i < DEPTH; i++) wb_write(BASE + 32'(4 * i), $urandom, 4'hF);

    // Byte-lane write.
    wb_write(BASE + 32'h8, 32'h0, 4'hF);
    wb_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'b0101);
    wb_read_check(BASE + 32'h8);
    check("sel_const", last_rd, 32'h00AD_00EF);

    // Out-of-range window: reads 0, writes dropped (incl. index aliasing).
    wb_read_check(BASE + 32'(4 * DEPTH));
    wb_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
    wb_write(BASE + 32'(4 * 1024), 32'hA5A5_A5A5, 4'hF);
    wb_write(BASE - 32'h4, 32'h5A5A_5A5A, 4'hF);
    wb_read_check(BASE - 32'h4);
    wb_read_check(BASE);
    wb_read_check(BASE + 32'(4 * (DEPTH - 1)));

    // Axon 3, consecutive words, idle again three cycles after acceptance.
    wb_write(BASE + 32'd24, 32'h1111_1111, 4'hF);
    wb_write(BASE + 32'd28, 32'h2222_2222, 4'hF);
    row_ready = 1'b1;
    request(3);
    step();
    check("def_v0",    32'(row_valid), 32'h1);
    check("def_d0",    row_data,       32'h1111_1111);
    check("def_w0",    32'(row_word),  32'h0);
    check("def_l0",    32'(row_last),  32'h0);
    step();
    check("def_v1",    32'(row_valid), 32'h1);
    check("def_d1",    row_data,       32'h2222_2222);
    check("def_w1",    32'(row_word),  32'h1);
    check("def_l1",    32'(row_last),  32'h1);
    check("def_rdy1",  32'(axon_ready), 32'h0);
    step();
    check("def_v2",    32'(row_valid),  32'h0);
    check("def_rdy2",  32'(axon_ready), 32'h1);
    check("def_busy2", 32'(busy),       32'h0);

    // Backpressure: word 0 held for five cycles, then the row resumes.
    row_ready = 1'b0;
    request(5);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(row_valid), 32'h1);
      check("bp_data",  row_data,       row_word_exp(5, 0));
      check("bp_word",  32'(row_word),  32'h0);
      check("bp_last",  32'(row_last),  32'h0);
      step();
    end
    collect(row_word_exp(5, 0), row_word_exp(5, 1), 1'b0);

    // Contention: WB read in the first stream-read cycle delays the row.
    row_ready = 1'b1;
    request(7);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'd40; sel = 4'hF;
    step();
    check("ct_ack",    32'(ack),       32'h1);
    check("ct_rdat",   rdat,           model[10]);
    check("ct_rvalid", 32'(row_valid), 32'h0);
    last_rd = model[10];
    cyc = 1'b0; stb = 1'b0;
    step();
    check("ct_ack_drop", 32'(ack),     32'h0);
    check("ct_v0",     32'(row_valid), 32'h1);
    check("ct_d0",     row_data,       model[14]);
    check("ct_w0",     32'(row_word),  32'h0);
    step();
    check("ct_d1",     row_data,       model[15]);
    check("ct_l1",     32'(row_last),  32'h1);
    step();
    check("ct_end",    32'(axon_ready), 32'h1);

    // Axon beyond the array streams zeros.
    request(300);
    collect(32'h0, 32'h0, 1'b0);
    request(511);
    collect(32'h0, 32'h0, 1'b1);

    // Writes during a stream affect only words not yet loaded.
    row_ready = 1'b0;
    request(9);
    step();
    old0 = model[18];
    new0 = ~old0;
    new1 = $urandom;
    wb_write(BASE + 32'd72, new0, 4'hF);
    wb_write(BASE + 32'd76, new1, 4'hF);
    collect(old0, new1, 1'b0);

    // Randomised rows, backpressure and WB traffic.
    for (int it = 0; it < 30; it++) begin
      ra = BASE + 32'(4 * $urandom_range(0, DEPTH + 8));
      wb_write(ra, $urandom, 4'($urandom_range(0, 15)));
      wb_read_check(BASE + 32'(4 * $urandom_range(0, DEPTH + 8)));
      ax = $urandom_range(0, 349);
      row_ready = 1'b1;
      request(ax);
      collect(row_word_exp(ax, 0), row_word_exp(ax, 1), 1'b1);
    end

    // Asynchronous reset with a row held and a WB write in flight.
    wb_read_check(BASE + 32'd24);
    row_ready = 1'b0;
    request(3);
    step();
    check("rs_pre_valid", 32'(row_valid), 32'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'd28; wdat = 32'h0; sel = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    last_rd = 32'h0;
    check_reset_values("async_rst");
    step();
    check("rs_no_ack", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    row_ready = 1'b1;
    step();
    check("rs_no_ack2", 32'(ack), 32'h0);
    check_reset_values("post_rst");
    wb_read_check(BASE + 32'd28);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
